// File: rtl/ecc_scrub_pkg.sv
// rtl/ecc_scrub_pkg.sv - shared types and constants for the ECC patrol scrubber
//
// Purpose: scrub FSM state encoding and command direction encodings used by
//          ecc_scrub_ctrl and its bench.
package ecc_scrub_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_TMR = 3'd1,
        RD_REQ   = 3'd2,
        RD_WAIT  = 3'd3,
        WB_REQ   = 3'd4,
        NEXT     = 3'd5
    } scrub_state_e;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/ecc_scrub_timer.sv
// rtl/ecc_scrub_timer.sv - loadable down-counter with zero flag
//
// Purpose: generic W-bit down-counter, used by the scrubber for both the
//          inter-read interval and the read-response timeout.
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high (count -> 0)
//   load_i     load load_val_i (has priority over dec_i)
//   load_val_i value to load
//   dec_i      decrement by one; holds at zero
//   zero_o     count is zero
module ecc_scrub_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - patrol-scrub sequencer for the 72/64 ECC datapath
//
// Purpose: walks the address window [base_addr, last_addr], issuing one read per
//          scrub interval. A correctable response (SBE or parity-bit error) is
//          written back so the engine re-encodes the check bits; a DBE is only
//          counted and its address logged. Missing responses set timeout_err.
// Optional feature macro: ECC_SCRUB_SYND_LOG_EN adds rsp_syndrome/last_syndrome.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   scrub_en, interval             enable, idle cycles between reads
//   base_addr, last_addr           scrub window (inclusive)
//   clr_counters                   clears sbe_count/dbe_count/timeout_err
//   cmd_valid/ready/write/addr/wdata  command channel to the memory arbiter
//   rsp_valid/data/sbe/dbe/parity  registered response from the ECC engine
//   busy, pass_done                status (pass_done pulses on window wrap)
//   sbe_count, dbe_count, dbe_addr, timeout_err   error statistics
//   rsp_syndrome, last_syndrome    (ECC_SCRUB_SYND_LOG_EN only) syndrome log
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ECC_WIDTH  = 8,
    parameter int INTERVAL_W = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scrub_en,
    input  logic [INTERVAL_W-1:0] interval,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic                  clr_counters,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_sbe,
    input  logic                  rsp_dbe,
    input  logic                  rsp_parity,
`ifdef ECC_SCRUB_SYND_LOG_EN
    input  logic [ECC_WIDTH-1:0]  rsp_syndrome,
    output logic [ECC_WIDTH-1:0]  last_syndrome,
`endif
    output logic                  busy,
    output logic                  pass_done,
    output logic [CNT_WIDTH-1:0]  sbe_count,
    output logic [CNT_WIDTH-1:0]  dbe_count,
    output logic [ADDR_WIDTH-1:0] dbe_addr,
    output logic                  timeout_err
);

    // The timeout timer is loaded with TIMEOUT-1 on read acceptance and the
    // wait ends on the cycle it is already zero, giving exactly TIMEOUT
    // RD_WAIT cycles.
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    scrub_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [INTERVAL_W-1:0] interval_q, interval_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] dbe_addr_q, dbe_addr_d;
    logic [CNT_WIDTH-1:0]  sbe_q, dbe_q;
    logic                  timeout_q, busy_q, pass_q;

    logic                  tmr_load, tmr_dec, tmr_zero;
    logic [INTERVAL_W-1:0] tmr_val;
    logic                  to_load, to_dec, to_zero;
    logic                  sbe_inc, dbe_inc, to_set, pass_d;

    ecc_scrub_timer #(.W(INTERVAL_W)) u_interval_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    ecc_scrub_timer #(.W(TO_W)) u_timeout_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (to_load),
        .load_val_i (TO_W'(TIMEOUT - 1)),
        .dec_i      (to_dec),
        .zero_o     (to_zero)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        interval_d = interval_q;
        wdata_d    = wdata_q;
        dbe_addr_d = dbe_addr_q;
        tmr_load   = 1'b0;
        tmr_val    = interval_q;
        tmr_dec    = 1'b0;
        to_load    = 1'b0;
        to_dec     = 1'b0;
        sbe_inc    = 1'b0;
        dbe_inc    = 1'b0;
        to_set     = 1'b0;
        pass_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (scrub_en) begin
                    ptr_d      = base_addr;
                    last_d     = last_addr;
                    interval_d = interval;
                    tmr_load   = 1'b1;
                    tmr_val    = interval;
                    state_d    = WAIT_TMR;
                end
            end
            WAIT_TMR: begin
                if (!scrub_en) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    state_d = RD_REQ;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            RD_REQ: begin
                if (cmd_ready) begin
                    to_load = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rsp_valid) begin
                    // DBE takes priority: the word cannot be repaired, so a
                    // simultaneous SBE flag must not trigger a writeback.
                    if (rsp_dbe) begin
                        dbe_inc    = 1'b1;
                        dbe_addr_d = ptr_q;
                        state_d    = NEXT;
                    end else if (rsp_sbe || rsp_parity) begin
                        // A flipped overall-parity bit leaves the data intact
                        // but the stored codeword is still wrong; rewrite it.
                        sbe_inc = 1'b1;
                        wdata_d = rsp_data;
                        state_d = WB_REQ;
                    end else begin
                        state_d = NEXT;
                    end
                end else if (to_zero) begin
                    to_set  = 1'b1;
                    state_d = NEXT;
                end else begin
                    to_dec = 1'b1;
                end
            end
            WB_REQ: begin
                if (cmd_ready) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (ptr_q >= last_q) begin
                    // Wrap point doubles as the config resample point.
                    ptr_d      = base_addr;
                    last_d     = last_addr;
                    interval_d = interval;
                    pass_d     = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                end
                if (scrub_en) begin
                    tmr_load = 1'b1;
                    tmr_val  = interval_d;
                    state_d  = WAIT_TMR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            last_q     <= '0;
            interval_q <= '0;
            wdata_q    <= '0;
            dbe_addr_q <= '0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            interval_q <= interval_d;
            wdata_q    <= wdata_d;
            dbe_addr_q <= dbe_addr_d;
            busy_q     <= (state_d != IDLE);
            pass_q     <= pass_d;
        end
    end

    // Statistics: clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_counters) begin
            sbe_q     <= '0;
            dbe_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (sbe_inc && (sbe_q != '1)) begin
                sbe_q <= sbe_q + CNT_WIDTH'(1);
            end
            if (dbe_inc && (dbe_q != '1)) begin
                dbe_q <= dbe_q + CNT_WIDTH'(1);
            end
            if (to_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef ECC_SCRUB_SYND_LOG_EN
    logic [ECC_WIDTH-1:0] synd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            synd_q <= '0;
        end else if ((state_q == RD_WAIT) && rsp_valid && (rsp_sbe || rsp_dbe)) begin
            synd_q <= rsp_syndrome;
        end
    end

    assign last_syndrome = synd_q;
`endif

    // Command fields come straight from registers, so they are stable for
    // the whole time cmd_valid is held waiting for cmd_ready.
    assign cmd_valid   = (state_q == RD_REQ) || (state_q == WB_REQ);
    assign cmd_write   = (state_q == WB_REQ) ? CMD_WR : CMD_RD;
    assign cmd_addr    = ptr_q;
    assign cmd_wdata   = wdata_q;
    assign busy        = busy_q;
    assign pass_done   = pass_q;
    assign sbe_count   = sbe_q;
    assign dbe_count   = dbe_q;
    assign dbe_addr    = dbe_addr_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb/tb_ecc_scrub_ctrl.sv - directed self-checking bench for ecc_scrub_ctrl
module tb_ecc_scrub_ctrl;

    logic        clk = 1'b0;
    logic        rst, scrub_en, clr_counters, cmd_ready;
    logic        rsp_valid, rsp_sbe, rsp_dbe, rsp_parity;
    logic [15:0] interval, base_addr, last_addr;
    logic [63:0] rsp_data;
    logic        cmd_valid, cmd_write, busy, pass_done, timeout_err;
    logic [15:0] cmd_addr, sbe_count, dbe_count, dbe_addr;
    logic [63:0] cmd_wdata;
`ifdef ECC_SCRUB_SYND_LOG_EN
    logic [7:0]  rsp_syndrome = 8'h00;
    logic [7:0]  last_syndrome;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ecc_scrub_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .scrub_en     (scrub_en),
        .interval     (interval),
        .base_addr    (base_addr),
        .last_addr    (last_addr),
        .clr_counters (clr_counters),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_sbe      (rsp_sbe),
        .rsp_dbe      (rsp_dbe),
        .rsp_parity   (rsp_parity),
`ifdef ECC_SCRUB_SYND_LOG_EN
        .rsp_syndrome (rsp_syndrome),
        .last_syndrome(last_syndrome),
`endif
        .busy         (busy),
        .pass_done    (pass_done),
        .sbe_count    (sbe_count),
        .dbe_count    (dbe_count),
        .dbe_addr     (dbe_addr),
        .timeout_err  (timeout_err)
    );

    // Bus monitor: values read at the posedge are the pre-edge values.
    int          cyc = 0;
    int          wr_cnt = 0;
    int          pass_cnt = 0;
    logic [15:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    int          rd_pass_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (cmd_valid && cmd_ready && !cmd_write) begin
                rd_addr_q.push_back(cmd_addr);
                rd_cyc_q.push_back(cyc);
                rd_pass_q.push_back(pass_cnt);
            end
            if (cmd_valid && cmd_ready && cmd_write) wr_cnt <= wr_cnt + 1;
            if (pass_done) pass_cnt <= pass_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for a read command, accept it, answer with the given flags and,
    // when a writeback is due, check it (and accept it if wb_ready).
    task automatic serve_read(input logic [15:0] addr, input logic sbe, input logic dbe,
                              input logic par, input logic [63:0] data, input logic clr,
                              input logic drop_en, input logic wb_ready);
        int   n;
        logic wb;
        n  = 0;
        wb = (sbe || par) && !dbe;
        while (!cmd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_req_seen", cmd_valid, 1'b1);
        check("rd_is_read", cmd_write, 1'b0);
        check("rd_addr", cmd_addr, addr);
        @(negedge clk);
        if (drop_en) begin
            scrub_en = 1'b0;
            repeat (3) @(negedge clk);
        end
        rsp_valid    = 1'b1;
        rsp_sbe      = sbe;
        rsp_dbe      = dbe;
        rsp_parity   = par;
        rsp_data     = data;
        clr_counters = clr;
        cmd_ready    = wb_ready;
        @(negedge clk);
        rsp_valid    = 1'b0;
        rsp_sbe      = 1'b0;
        rsp_dbe      = 1'b0;
        rsp_parity   = 1'b0;
        clr_counters = 1'b0;
        if (wb) begin
            check("wb_valid", cmd_valid && cmd_write, 1'b1);
            check("wb_addr", cmd_addr, addr);
            check("wb_data", cmd_wdata, data);
            if (wb_ready) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, stable, sz, pc0;
        rst = 1'b1; scrub_en = 1'b0; clr_counters = 1'b0; cmd_ready = 1'b1;
        rsp_valid = 1'b0; rsp_sbe = 1'b0; rsp_dbe = 1'b0; rsp_parity = 1'b0;
        rsp_data = '0; interval = 16'd2; base_addr = 16'd0; last_addr = 16'd3;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pass_done", pass_done, 1'b0);
        check("rst_sbe_count", sbe_count, 16'd0);
        check("rst_dbe_count", dbe_count, 16'd0);
        check("rst_dbe_addr", dbe_addr, 16'd0);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_cmd_addr", cmd_addr, 16'd0);

        // 1: clean pass over 0..3 then wrap to 0
        scrub_en = 1'b1;
        serve_read(16'd0, 0, 0, 0, 64'h0, 0, 0, 1);
        check("t1_busy", busy, 1'b1);
        serve_read(16'd1, 0, 0, 0, 64'h0, 0, 0, 1);
        serve_read(16'd2, 0, 0, 0, 64'h0, 0, 0, 1);
        serve_read(16'd3, 0, 0, 0, 64'h0, 0, 0, 1);
        serve_read(16'd0, 0, 0, 0, 64'h0, 0, 0, 1);
        check("t1_read_spacing", 64'(rd_cyc_q[1] - rd_cyc_q[0]), 64'd6);
        check("t1_no_pass_before_3", 64'(rd_pass_q[3]), 64'd0);
        check("t1_pass_after_3", 64'(rd_pass_q[4]), 64'd1);
        check("t1_no_writes", 64'(wr_cnt), 64'd0);

        // 2: SBE on address 2 -> writeback of corrected word
        serve_read(16'd1, 0, 0, 0, 64'h0, 0, 0, 1);
        serve_read(16'd2, 1, 0, 0, 64'hA5A5, 0, 0, 1);
        check("t2_sbe_count", sbe_count, 16'd1);
        check("t2_wr_cnt", 64'(wr_cnt), 64'd1);

        // 3: DBE on address 1 -> logged, no writeback
        serve_read(16'd3, 0, 0, 0, 64'h0, 0, 0, 1);
        serve_read(16'd0, 0, 0, 0, 64'h0, 0, 0, 1);
        serve_read(16'd1, 0, 1, 0, 64'hFFFF, 0, 0, 1);
        check("t3_dbe_count", dbe_count, 16'd1);
        check("t3_dbe_addr", dbe_addr, 16'd1);
        check("t3_no_write", 64'(wr_cnt), 64'd1);

        // parity-bit error counts as SBE and is rewritten
        serve_read(16'd2, 0, 0, 1, 64'h1234_5678_9ABC_DEF0, 0, 0, 1);
        check("par_sbe_count", sbe_count, 16'd2);
        check("par_wr_cnt", 64'(wr_cnt), 64'd2);

        // 4: arbiter stalls for 10 cycles
        cmd_ready = 1'b0;
        n = 0;
        while (!cmd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        sz = rd_addr_q.size();
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid && !cmd_write && cmd_addr == 16'd3) stable++;
            @(negedge clk);
        end
        check("t4_stable_cycles", 64'(stable), 64'd10);
        check("t4_no_early_accept", 64'(rd_addr_q.size()), 64'(sz));
        cmd_ready = 1'b1;
        serve_read(16'd3, 0, 0, 0, 64'h0, 0, 0, 1);

        // 5: no response -> timeout after 255 cycles
        n = 0;
        while (!cmd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_rd_addr", cmd_addr, 16'd0);
        @(negedge clk);
        n = 0;
        while (!timeout_err && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t5_timeout_cycles", 64'(n), 64'd255);
        check("t5_timeout_err", timeout_err, 1'b1);
        // stray response outside RD_WAIT must be ignored
        rsp_valid = 1'b1;
        rsp_dbe   = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_dbe   = 1'b0;
        check("stray_rsp_dbe_count", dbe_count, 16'd1);
        clr_counters = 1'b1;
        @(negedge clk);
        clr_counters = 1'b0;
        check("t5_clr_timeout", timeout_err, 1'b0);
        check("t5_clr_sbe", sbe_count, 16'd0);
        check("t5_clr_dbe", dbe_count, 16'd0);
        serve_read(16'd1, 0, 0, 0, 64'h0, 0, 0, 1);

        // clear in the same cycle as an SBE increment: clear wins
        serve_read(16'd2, 1, 0, 0, 64'h0F0F, 1, 0, 1);
        check("clr_wins", sbe_count, 16'd0);

        // 6: scrub_en dropped in RD_WAIT -> finish writeback, then IDLE
        serve_read(16'd3, 1, 0, 0, 64'hC3C3, 0, 1, 1);
        @(negedge clk);
        check("t6_busy_idle", busy, 1'b0);
        check("t6_cmd_idle", cmd_valid, 1'b0);
        sz = rd_addr_q.size();
        repeat (5) @(negedge clk);
        check("t6_no_more_reads", 64'(rd_addr_q.size()), 64'(sz));
        check("t6_sbe_count", sbe_count, 16'd1);
        check("t6_wr_cnt", 64'(wr_cnt), 64'd4);

        // base > last: only base address is scrubbed, each read wraps
        base_addr = 16'd7;
        last_addr = 16'd4;
        interval  = 16'd0;
        pc0       = pass_cnt;
        scrub_en  = 1'b1;
        serve_read(16'd7, 0, 0, 0, 64'h0, 0, 0, 1);
        serve_read(16'd7, 0, 0, 0, 64'h0, 0, 0, 1);
        serve_read(16'd7, 1, 0, 0, 64'hDEAD_BEEF, 0, 0, 0);
        check("inv_window_passes", 64'(pass_cnt - pc0), 64'd2);
        check("inv_window_sbe", sbe_count, 16'd2);

        // reset while the writeback is stalled
        rst = 1'b1;
        @(negedge clk);
        check("rst_wb_cmd_valid", cmd_valid, 1'b0);
        check("rst_wb_busy", busy, 1'b0);
        check("rst_wb_sbe", sbe_count, 16'd0);
        check("rst_wb_addr", cmd_addr, 16'd0);
        rst = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
